// File: rtl/serial_subtract_ctrl.sv
// Bit-serial unsigned subtractor: computes (A - B) mod 2^WIDTH and the final borrow
// one bit per cycle, LSB first, through a single shared 1-bit full subtractor.
module serial_subtract_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inStart,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] outD,
    output logic             outB,
    output logic             outBusy,
    output logic             outDone
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;

    logic a_bit, b_bit, d_bit, borrow_next;

    // Shared 1-bit full subtractor; operands shift right so bit cnt is always at position 0.
    always_comb begin
        a_bit       = a_q[0];
        b_bit       = b_q[0];
        d_bit       = a_bit ^ b_bit ^ borrow_q;
        borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        bout_d   = bout_q;

        case (state_q)
            S_IDLE: begin
                if (inStart) begin
                    a_d      = inA;
                    b_d      = inB;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                d_d[cnt_q] = d_bit;
                borrow_d   = borrow_next;
                a_d        = a_q >> 1;
                b_d        = b_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    bout_d  = borrow_next;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign outD    = d_q;
    assign outB    = bout_q;
    assign outBusy = (state_q != S_IDLE);
    assign outDone = (state_q == S_DONE);

endmodule
